ram_bridge16: RTL
=================

Name: ram_bridge16

Overview:
- Sits directly downstream of the machine assembly's RAM port: 32-bit CPU RAM bus cycles in, one 16-bit external memory port out.
- Each CPU access becomes one or two sequential 16-bit memory transactions (low halfword, then high).
- Reads are reassembled into 32 bits; completion is signalled with an active-low ready.
- Memory side runs on every CLK; CPU-side sampling is qualified by CE.

Parameters:
- MEM_AW, 21: width of MEM_A, a halfword address. Bits above the CPU span are tied 0.
- ZERO_WR_SKIP, 1: when 1, a write with all four BEn high completes without any memory transaction.

Ports:
- CLK  in  1  system clock.
- RESn  in  1  reset. Synchronous, active-low.
- CE  in  1  CPU clock enable. CPU samples RAM_READYn only on CE cycles.
- BCYSTn  in  1  CPU bus-cycle-start strobe. Low on the first CE cycle of each bus cycle.
- RAM_A  in  21  CPU byte address. Bits [1:0] are ignored.
- RAM_DI  in  32  CPU write data.
- RAM_DO  out  32  read data to CPU.
- RAM_CEn  in  1  RAM select, active-low.
- RAM_WEn  in  1  1=read, 0=write.
- RAM_BEn  in  4  byte enables, active-low. Bit0 = bits [7:0].
- RAM_READYn  out  1  cycle complete, active-low.
- MEM_A  out  MEM_AW  halfword address.
- MEM_DI  out  16  write data to memory.
- MEM_DO  in  16  read data from memory. Valid on the MEM_ACK cycle.
- MEM_RD  out  1  read request, level.
- MEM_WR  out  1  write request, level.
- MEM_BE  out  2  byte enables, active-high.
- MEM_ACK  in  1  one-CLK completion pulse from memory.

Behaviour:
- Reset values (RESn low at a CLK edge): state IDLE, RAM_READYn=1, RAM_DO=0, MEM_RD=0, MEM_WR=0, MEM_BE=0, MEM_A=0, MEM_DI=0. Reset mid-transaction aborts it. A MEM_ACK arriving after reset is ignored.
- Start condition: CE=1 & BCYSTn=0 & RAM_CEn=0 while in IDLE.
  - At start, latch: address, write flag (~RAM_WEn), data, per-half enables.
  - loen = ~BEn[1] | ~BEn[0]; hien = ~BEn[3] | ~BEn[2].
  - Reads force loen = hien = 1.
- States: IDLE, LO, HI, DONE.
- From IDLE at start:
  - Go to LO if loen.
  - Else go to HI if hien.
  - Else go to DONE. This is a zero-enable write with ZERO_WR_SKIP=1.
  - With ZERO_WR_SKIP=0, a zero-enable write still issues LO with MEM_BE=00.
- In LO:
  - MEM_A = {addr[20:2],0}.
  - MEM_BE = ~BEn[1:0] for writes, 11 for reads.
  - MEM_DI = data[15:0].
  - MEM_RD or MEM_WR is held high until MEM_ACK.
  - On MEM_ACK: a read captures MEM_DO into RAM_DO[15:0]. Next state is HI if hien, else DONE. The request drops in the same edge.
  - A request may not be held across the LO→HI transition. There is at least one CLK with MEM_RD=MEM_WR=0 between halves.
- HI: as LO, but MEM_A = {addr[20:2],1}, MEM_BE = ~BEn[3:2] (or 11 for reads), MEM_DI = data[31:16]. A read captures into RAM_DO[31:16]. Next state is DONE.
- DONE:
  - RAM_READYn=0.
  - Held until the first CE=1 cycle. At that edge: RAM_READYn←1, state→IDLE.
  - A start condition on that same CE edge is not accepted; the CPU cannot issue BCYSTn before seeing ready.
- RAM_DO holds its last value until overwritten. Read data is stable from the DONE entry through the CE cycle.
- Memory latency is unbounded. MEM_ACK in IDLE or DONE is ignored.
- RAM_CEn rising mid-transaction does not abort; the transaction completes.
- A CE=0 start condition is ignored.
- Minimum latency, 1-cycle ACK, both halves: start edge → LO, ACK → gap, HI, ACK → DONE. RAM_READYn is low from the fifth CLK after start.

Test Plan:
- Read, addr 0x000104, BEn=0000; memory returns 0x1234 @ halfword 0x82 and 0xABCD @ 0x83 → MEM_A 0x82 then 0x83, MEM_BE=11 both, RAM_DO=0xABCD1234, RAM_READYn low exactly until the next CE.
- Write 0xDEADBEEF to addr 0x000010, BEn=1100 → single MEM_WR, MEM_A=0x08, MEM_BE=11, MEM_DI=0xBEEF; no HI access.
- Write, BEn=0111 to addr 0x20 → only HI access, MEM_A=0x11, MEM_BE=10, MEM_DI=data[31:16].
- Write, BEn=1111, ZERO_WR_SKIP=1 → no MEM_WR; RAM_READYn low on the following CLK until CE.
- Read with ACK delayed 7 CLKs per half, CE=1 every 3rd CLK → MEM_RD held until ACK with a gap between halves; RAM_READYn released at the first CE after DONE; back-to-back BCYSTn accepted afterward.
- RESn low during HI wait → next cycle all outputs at reset values; a late MEM_ACK is ignored; a new read completes normally.

Source files
------------

// File: rtl/ram_bridge16.sv
// ram_bridge16
//
// Purpose:
//    Bridges 32-bit CPU RAM bus cycles onto a single 16-bit external memory
//    port. Each CPU access is split into a low-halfword transaction followed
//    by a high-halfword transaction; halves with no enabled bytes are skipped.
//    Read halves are reassembled into RAM_DO. Completion is reported to the
//    CPU with an active-low RAM_READYn that is held until the CPU's next CE
//    cycle. The memory side advances on every CLK; CPU-side sampling
//    (start detection and ready release) is qualified by CE.
//
// Ports:
//    CLK         system clock
//    RESn        synchronous active-low reset
//    CE          CPU clock enable
//    BCYSTn      CPU bus-cycle-start strobe (active low)
//    RAM_A       CPU byte address (bits [1:0] ignored)
//    RAM_DI      CPU write data
//    RAM_DO      reassembled read data to the CPU
//    RAM_CEn     RAM select (active low)
//    RAM_WEn     1 = read, 0 = write
//    RAM_BEn     byte enables (active low), bit 0 covers [7:0]
//    RAM_READYn  cycle complete (active low)
//    MEM_A       halfword address to memory
//    MEM_DI      write data to memory
//    MEM_DO      read data from memory, valid on the MEM_ACK cycle
//    MEM_RD      read request (level, held until MEM_ACK)
//    MEM_WR      write request (level, held until MEM_ACK)
//    MEM_BE      byte enables to memory (active high)
//    MEM_ACK     one-CLK completion pulse from memory

module ram_bridge16 #(
   parameter int MEM_AW       = 21,
   parameter bit ZERO_WR_SKIP = 1'b1
) (
   input  logic              CLK,
   input  logic              RESn,
   input  logic              CE,
   input  logic              BCYSTn,
   input  logic [20:0]       RAM_A,
   input  logic [31:0]       RAM_DI,
   output logic [31:0]       RAM_DO,
   input  logic              RAM_CEn,
   input  logic              RAM_WEn,
   input  logic [3:0]        RAM_BEn,
   output logic              RAM_READYn,
   output logic [MEM_AW-1:0] MEM_A,
   output logic [15:0]       MEM_DI,
   input  logic [15:0]       MEM_DO,
   output logic              MEM_RD,
   output logic              MEM_WR,
   output logic [1:0]        MEM_BE,
   input  logic              MEM_ACK
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LO   = 2'd1,
      S_HI   = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_state_next;

   logic [18:0] r_addr;      // word address, RAM_A[20:2]
   logic        r_wr;
   logic [31:0] r_data;
   logic [3:0]  r_be;        // active-high byte enables, all ones for reads
   logic        r_hien;
   logic        r_hi_go;     // HI request may be driven (low for the gap cycle after LO)
   logic [31:0] r_ram_do;

   logic        w_start;
   logic        w_wr;
   logic        w_loen;
   logic        w_hien;
   logic        w_lo_go;
   logic        w_unused_a;

   // The byte offset within the word carries no meaning on a 32-bit bus.
   assign w_unused_a = ^RAM_A[1:0];

   assign w_start = CE & ~BCYSTn & ~RAM_CEn & (r_state == S_IDLE);
   assign w_wr    = ~RAM_WEn;
   // Reads always fetch both halves regardless of the byte enables.
   assign w_loen  = ~w_wr | ~RAM_BEn[1] | ~RAM_BEn[0];
   assign w_hien  = ~w_wr | ~RAM_BEn[3] | ~RAM_BEn[2];
   // Without the skip option a write with no enables still produces one
   // LO transaction carrying MEM_BE = 00.
   assign w_lo_go = w_loen | ((ZERO_WR_SKIP == 1'b0) & ~w_hien);

   // ---------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (!RESn) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ---------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_start) begin
               if (w_lo_go) begin
                  w_state_next = S_LO;
               end else if (w_hien) begin
                  w_state_next = S_HI;
               end else begin
                  w_state_next = S_DONE;
               end
            end
         end
         S_LO: begin
            if (MEM_ACK) begin
               w_state_next = r_hien ? S_HI : S_DONE;
            end
         end
         S_HI: begin
            // An ACK during the gap cycle cannot belong to the HI request.
            if (r_hi_go && MEM_ACK) begin
               w_state_next = S_DONE;
            end
         end
         S_DONE: begin
            if (CE) begin
               w_state_next = S_IDLE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------
   // Datapath: request latch, gap control, read reassembly
   // ---------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (!RESn) begin
         r_addr   <= '0;
         r_wr     <= 1'b0;
         r_data   <= '0;
         r_be     <= '0;
         r_hien   <= 1'b0;
         r_hi_go  <= 1'b0;
         r_ram_do <= '0;
      end else begin
         if (w_start) begin
            r_addr <= RAM_A[20:2];
            r_wr   <= w_wr;
            r_data <= RAM_DI;
            r_be   <= w_wr ? ~RAM_BEn : 4'b1111;
            r_hien <= w_hien;
         end
         // Entering HI from LO leaves the request low for one CLK; entering
         // HI straight from IDLE has no previous request to separate from.
         r_hi_go <= (w_state_next == S_HI) && (r_state != S_LO);
         if (r_state == S_LO && MEM_ACK && !r_wr) begin
            r_ram_do[15:0] <= MEM_DO;
         end
         if (r_state == S_HI && r_hi_go && MEM_ACK && !r_wr) begin
            r_ram_do[31:16] <= MEM_DO;
         end
      end
   end

   assign RAM_DO = r_ram_do;

   // ---------------------------------------------------------------
   // Output decode
   // ---------------------------------------------------------------
   always_comb begin
      MEM_A      = '0;
      MEM_DI     = '0;
      MEM_BE     = '0;
      MEM_RD     = 1'b0;
      MEM_WR     = 1'b0;
      RAM_READYn = 1'b1;
      case (r_state)
         S_LO: begin
            MEM_A  = MEM_AW'({r_addr, 1'b0});
            MEM_DI = r_data[15:0];
            MEM_BE = r_be[1:0];
            MEM_RD = ~r_wr;
            MEM_WR = r_wr;
         end
         S_HI: begin
            MEM_A  = MEM_AW'({r_addr, 1'b1});
            MEM_DI = r_data[31:16];
            MEM_BE = r_be[3:2];
            MEM_RD = ~r_wr & r_hi_go;
            MEM_WR = r_wr & r_hi_go;
         end
         S_DONE: begin
            RAM_READYn = 1'b0;
         end
         default: begin
            RAM_READYn = 1'b1;
         end
      endcase
   end

endmodule
